// File: rtl/mmio_timer_pkg.sv
// Shared register map, CTRL bit positions and reset constants for the
// memory-mapped timer peripheral.
package mmio_timer_pkg;

  localparam logic [1:0] OFS_CTRL    = 2'd0;
  localparam logic [1:0] OFS_COUNT   = 2'd1;
  localparam logic [1:0] OFS_COMPARE = 2'd2;
  localparam logic [1:0] OFS_STATUS  = 2'd3;

  localparam int CTRL_EN           = 0;
  localparam int CTRL_AUTO_RELOAD  = 1;
  localparam int CTRL_IRQ_EN       = 2;
  localparam int CTRL_PRESCALE_LSB = 8;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // The run state is a view of CTRL.EN, never a separate register.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mmio_timer_tick_gen.sv
// Prescaler: counts 0..prescale while enabled and pulses tick for one cycle
// when the count reaches prescale, giving one tick every prescale+1 cycles.
module tick_gen #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = enable && (pre_cnt_q == prescale);

  always_comb begin
    // NOTE: give every always_comb output a value up front so no path leaves it unassigned and infers a latch.
    pre_cnt_d = pre_cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    if (clear || !enable || tick) begin
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: prescaled up-counter with compare match,
// one-shot or auto-reload operation, and a level interrupt.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic        irq
);

  logic                  en_q, en_d;
  logic                  auto_reload_q, auto_reload_d;
  logic                  irq_en_q, irq_en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic                  match_q, match_d;

  logic [1:0]  ofs;
  logic        wr_en, wr_ctrl, wr_count, wr_compare, wr_status;
  logic        tick, is_match;
  logic [31:0] ctrl_word;
  state_e      state;

  assign hit   = (DataAdr >= BASE_ADDR) && (DataAdr <= BASE_ADDR + 32'd15);
  assign ofs   = DataAdr[3:2];
  assign wr_en = MemWrite && hit && (DataAdr[1:0] == 2'b00);

  assign wr_ctrl    = wr_en && (ofs == OFS_CTRL);
  assign wr_count   = wr_en && (ofs == OFS_COUNT);
  assign wr_compare = wr_en && (ofs == OFS_COMPARE);
  assign wr_status  = wr_en && (ofs == OFS_STATUS);

  assign state    = en_q ? ST_RUN : ST_IDLE;
  assign is_match = (count_q == compare_q);
  assign irq      = match_q && irq_en_q;

  tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .enable   (state == ST_RUN),
    .clear    (wr_ctrl),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_comb begin
    en_d          = en_q;
    auto_reload_d = auto_reload_q;
    irq_en_d      = irq_en_q;
    prescale_d    = prescale_q;
    count_d       = count_q;
    compare_d     = compare_q;

    if (tick) begin
      if (is_match) begin
        if (auto_reload_q) count_d = '0;
        else               en_d    = 1'b0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    // Bus writes are applied last so they override the tick update.
    if (wr_ctrl) begin
      en_d          = WriteData[CTRL_EN];
      auto_reload_d = WriteData[CTRL_AUTO_RELOAD];
      irq_en_d      = WriteData[CTRL_IRQ_EN];
      prescale_d    = WriteData[CTRL_PRESCALE_LSB +: PRESCALE_W];
    end
    if (wr_count)   count_d   = WriteData;
    if (wr_compare) compare_d = WriteData;

    // A match in the same cycle as a write-1-to-clear keeps MATCH set.
    match_d = (match_q && !(wr_status && WriteData[0])) || (tick && is_match);
  end

  always_comb begin
    ctrl_word                                        = '0;
    ctrl_word[CTRL_EN]                               = en_q;
    ctrl_word[CTRL_AUTO_RELOAD]                      = auto_reload_q;
    ctrl_word[CTRL_IRQ_EN]                           = irq_en_q;
    ctrl_word[CTRL_PRESCALE_LSB +: PRESCALE_W]       = prescale_q;

    ReadData = '0;
    if (hit) begin
      case (ofs)
        OFS_CTRL:    ReadData = ctrl_word;
        OFS_COUNT:   ReadData = count_q;
        OFS_COMPARE: ReadData = compare_q;
        default:     ReadData = {31'b0, match_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register is reset because software reads any of them right after reset.
      en_q          <= 1'b0;
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      prescale_q    <= '0;
      count_q       <= '0;
      compare_q     <= COMPARE_RST;
      match_q       <= 1'b0;
    end else begin
      en_q          <= en_d;
      auto_reload_q <= auto_reload_d;
      irq_en_q      <= irq_en_d;
      prescale_q    <= prescale_d;
      count_q       <= count_d;
      compare_q     <= compare_d;
      match_q       <= match_d;
    end
  end

endmodule
